// File: rtl/prime_display_monitor_pkg.sv
// Shared types, display constants and code-table helpers for the prime-sequence
// display monitor.
package prime_display_monitor_pkg;

   typedef enum logic {
      DIG_ONES = 1'b0,
      DIG_TENS = 1'b1
   } dig_sel_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   function automatic logic is_legal(input logic [3:0] v);
      case (v)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: is_legal = 1'b1;
         default:                                          is_legal = 1'b0;
      endcase
   endfunction

   // Returns {valid, successor}; illegal codes have no successor (valid=0).
   function automatic logic [4:0] succ_of(input logic [3:0] v);
      case (v)
         4'd0:    succ_of = {1'b1, 4'd3};
         4'd3:    succ_of = {1'b1, 4'd5};
         4'd5:    succ_of = {1'b1, 4'd7};
         4'd7:    succ_of = {1'b1, 4'd11};
         4'd11:   succ_of = {1'b1, 4'd13};
         4'd13:   succ_of = {1'b1, 4'd1};
         4'd1:    succ_of = {1'b1, 4'd2};
         4'd2:    succ_of = {1'b1, 4'd3};
         default: succ_of = {1'b0, 4'd0};
      endcase
   endfunction

endpackage

// File: rtl/prime_display_monitor_if.sv
// Counter-value input and display/flag outputs of the prime display monitor.
interface prime_display_monitor_if;
   logic [3:0] value;
   logic [6:0] seg;
   logic [1:0] an;
   logic       code_err;
   logic       seq_err;
   logic [3:0] cur_val;

   modport master (output value, input seg, input an, input code_err, input seq_err, input cur_val);
   modport slave  (input value, output seg, output an, output code_err, output seq_err, output cur_val);
endinterface

// File: rtl/prime_display_monitor_seg7_decoder.sv
// Decimal digit to active-low seven-segment pattern (g..a); non-decimal inputs blank.
module seg7_decoder
   import prime_display_monitor_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   always_comb begin
      case (i_digit)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/prime_display_monitor.sv
// Samples the prime-sequence counter, flags illegal codes and broken successions,
// and scans the sampled value onto a two-digit active-low display.
module prime_display_monitor
   import prime_display_monitor_pkg::*;
#(
   parameter int SCAN_BITS = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   prime_display_monitor_if.slave  bus
);

   localparam logic [SCAN_BITS-1:0] SCAN_ONE = {{(SCAN_BITS-1){1'b0}}, 1'b1};

   logic [3:0]           r_val;
   logic                 r_have;
   logic [SCAN_BITS-1:0] r_scan;
   dig_sel_t             r_dig_sel;
   logic [6:0]           r_seg;
   logic [1:0]           r_an;
   logic                 r_code_err;
   logic                 r_seq_err;

   logic [3:0] w_ones;
   logic [3:0] w_digit;
   logic [6:0] w_pat;
   logic [6:0] w_seg_next;
   logic [1:0] w_an_next;
   logic [4:0] w_succ;
   logic       w_seq_bad;

   // Digit to decode: ones place of the sample, or a constant 1 for the tens place.
   always_comb begin
      w_ones = (r_val >= 4'd10) ? (r_val - 4'd10) : r_val;
      if (r_dig_sel == DIG_ONES) begin
         w_digit = w_ones;
      end else begin
         w_digit = 4'd1;
      end
   end

   seg7_decoder u_seg7 (
      .i_digit (w_digit),
      .o_seg   (w_pat)
   );

   // Next display state; the tens digit is blanked for single-digit values.
   always_comb begin
      if (r_dig_sel == DIG_ONES) begin
         w_an_next  = 2'b10;
         w_seg_next = w_pat;
      end else if (r_val >= 4'd10) begin
         w_an_next  = 2'b01;
         w_seg_next = w_pat;
      end else begin
         w_an_next  = 2'b11;
         w_seg_next = SEG_BLANK;
      end
   end

   // An illegal previous sample has no successor, so anything after it mismatches.
   always_comb begin
      w_succ    = succ_of(r_val);
      w_seq_bad = r_have && (!w_succ[4] || (bus.value != w_succ[3:0]));
   end

   // Sampling, sticky checks, digit scan and registered display outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_val      <= 4'd0;
         r_have     <= 1'b0;
         r_scan     <= '0;
         r_dig_sel  <= DIG_ONES;
         r_seg      <= SEG_BLANK;
         r_an       <= 2'b11;
         r_code_err <= 1'b0;
         r_seq_err  <= 1'b0;
      end else begin
         r_val  <= bus.value;
         r_have <= 1'b1;
         r_scan <= r_scan + SCAN_ONE;
         if (&r_scan) begin
            r_dig_sel <= (r_dig_sel == DIG_ONES) ? DIG_TENS : DIG_ONES;
         end
         if (!is_legal(bus.value)) begin
            r_code_err <= 1'b1;
         end
         if (w_seq_bad) begin
            r_seq_err <= 1'b1;
         end
         r_seg <= w_seg_next;
         r_an  <= w_an_next;
      end
   end

   assign bus.seg      = r_seg;
   assign bus.an       = r_an;
   assign bus.code_err = r_code_err;
   assign bus.seq_err  = r_seq_err;
   assign bus.cur_val  = r_val;

endmodule

// File: tb/tb_prime_display_monitor.sv
// Scoreboard bench for prime_display_monitor with a fast digit scan (SCAN_BITS=2).
module tb_prime_display_monitor;

   typedef struct {
      logic [3:0] cur;
      logic       code;
      logic       seq;
      logic [6:0] seg;
      logic [1:0] an;
   } exp_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   exp_t sb_q[$];

   logic [6:0] pat [0:9];
   logic [3:0] m_val;
   logic       m_have;
   logic [1:0] m_scan;
   logic       m_tens;
   logic       m_code;
   logic       m_seq;

   prime_display_monitor_if u_if ();

   prime_display_monitor #(.SCAN_BITS(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic bit tb_legal(input logic [3:0] v);
      return (v == 4'd0) || (v == 4'd1) || (v == 4'd2) || (v == 4'd3) ||
             (v == 4'd5) || (v == 4'd7) || (v == 4'd11) || (v == 4'd13);
   endfunction

   function automatic int tb_succ(input logic [3:0] v);
      case (v)
         4'd0:    return 3;
         4'd3:    return 5;
         4'd5:    return 7;
         4'd7:    return 11;
         4'd11:   return 13;
         4'd13:   return 1;
         4'd1:    return 2;
         4'd2:    return 3;
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      m_val = 4'd0; m_have = 1'b0; m_scan = 2'd0; m_tens = 1'b0;
      m_code = 1'b0; m_seq = 1'b0;
   endtask

   // Predicts the DUT outputs visible right after the edge that samples v.
   task automatic model_step(input logic [3:0] v);
      exp_t e;
      int   d;
      if (!m_tens) begin
         d = (m_val >= 4'd10) ? int'(m_val) - 10 : int'(m_val);
         e.an = 2'b10; e.seg = pat[d];
      end else if (m_val >= 4'd10) begin
         e.an = 2'b01; e.seg = pat[1];
      end else begin
         e.an = 2'b11; e.seg = 7'h7F;
      end
      if (!tb_legal(v)) m_code = 1'b1;
      if (m_have && (tb_succ(m_val) != int'(v))) m_seq = 1'b1;
      if (m_scan == 2'd3) m_tens = ~m_tens;
      m_scan = m_scan + 2'd1;
      m_val  = v;
      m_have = 1'b1;
      e.cur = v; e.code = m_code; e.seq = m_seq;
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic [3:0] v);
      exp_t e;
      u_if.value = v;
      model_step(v);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check("cur_val",  32'(u_if.cur_val),  32'(e.cur));
         check("code_err", 32'(u_if.code_err), 32'(e.code));
         check("seq_err",  32'(u_if.seq_err),  32'(e.seq));
         check("seg",      32'(u_if.seg),      32'(e.seg));
         check("an",       32'(u_if.an),       32'(e.an));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_seg"},  32'(u_if.seg),      32'h7F);
      check({tag, "_an"},   32'(u_if.an),       32'h3);
      check({tag, "_code"}, 32'(u_if.code_err), 32'd0);
      check({tag, "_seq"},  32'(u_if.seq_err),  32'd0);
      check({tag, "_cur"},  32'(u_if.cur_val),  32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ones_cnt;
      int tens_cnt;
      logic [3:0] t1 [0:8];
      pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30; pat[4] = 7'h19;
      pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78; pat[8] = 7'h00; pat[9] = 7'h10;
      t1[0] = 4'd0; t1[1] = 4'd3; t1[2] = 4'd5; t1[3] = 4'd7; t1[4] = 4'd11;
      t1[5] = 4'd13; t1[6] = 4'd1; t1[7] = 4'd2; t1[8] = 4'd3;
      n_checks = 0;
      n_errors = 0;
      model_reset();
      u_if.value = 4'd0;
      reset = 1'b1;
      #2;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Legal sequence: flags stay clear, cur_val follows one edge late.
      for (int i = 0; i < 9; i++) drive(t1[i]);
      check("seq_clean_code", 32'(u_if.code_err), 32'd0);
      check("seq_clean_seq",  32'(u_if.seq_err),  32'd0);

      // Legal code but wrong successor.
      drive(4'd5);
      drive(4'd11);
      check("wrong_succ_seq",  32'(u_if.seq_err),  32'd1);
      check("wrong_succ_code", 32'(u_if.code_err), 32'd0);

      // Asynchronous reset mid-scan with seq_err set.
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      sb_q.delete();
      @(negedge clk);
      reset = 1'b0;
      drive(4'd7);
      check("post_reset_first_seq", 32'(u_if.seq_err), 32'd0);
      drive(4'd11);
      check("post_reset_second_seq", 32'(u_if.seq_err), 32'd0);

      // Illegal code after 3,5 sets both flags; they stay set on a legal return.
      drive(4'd13); drive(4'd1); drive(4'd2); drive(4'd3); drive(4'd5);
      drive(4'd9);
      check("illegal_code", 32'(u_if.code_err), 32'd1);
      check("illegal_seq",  32'(u_if.seq_err),  32'd1);
      drive(4'd7); drive(4'd11); drive(4'd13);
      check("sticky_code", 32'(u_if.code_err), 32'd1);
      check("sticky_seq",  32'(u_if.seq_err),  32'd1);

      // Hold 13: ones digit 3 and tens digit 1 each shown half the time.
      drive(4'd13); drive(4'd13);
      ones_cnt = 0; tens_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         drive(4'd13);
         if (u_if.an == 2'b10 && u_if.seg == 7'h30) ones_cnt++;
         if (u_if.an == 2'b01 && u_if.seg == 7'h79) tens_cnt++;
      end
      check("hold13_ones", 32'(ones_cnt), 32'd8);
      check("hold13_tens", 32'(tens_cnt), 32'd8);

      // Hold 7: ones digit 7, tens digit blanked.
      drive(4'd7); drive(4'd7);
      ones_cnt = 0; tens_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         drive(4'd7);
         if (u_if.an == 2'b10 && u_if.seg == 7'h78) ones_cnt++;
         if (u_if.an == 2'b11 && u_if.seg == 7'h7F) tens_cnt++;
      end
      check("hold7_ones",  32'(ones_cnt), 32'd8);
      check("hold7_blank", 32'(tens_cnt), 32'd8);

      // Remaining non-prime values exercise the ones-digit modulo path.
      drive(4'd15); drive(4'd15); drive(4'd10); drive(4'd14); drive(4'd4);
      drive(4'd12); drive(4'd6); drive(4'd8);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/prime_display_monitor.md
Name: prime_display_monitor

Overview:
Downstream consumer of the 4-bit prime-sequence counter in the same clock domain. Each cycle it samples the counter value and checks that value against the counter's legal code set and its fixed successor table, raising sticky error flags on a mismatch. It also drives a 2-digit, time-multiplexed, active-low seven-segment display showing the sampled value in decimal (0..15).

Parameters:
SCAN_BITS, 16, width of the digit-scan counter; the digit select toggles every 2^SCAN_BITS clocks (tests use 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
value  input  4  counter output, sampled every rising edge
seg  output  7  active-low segments, bit0=a .. bit6=g
an  output  2  active-low digit enables; an[0]=ones, an[1]=tens
code_err  output  1  sticky: a value outside {0,1,2,3,5,7,11,13} was sampled
seq_err  output  1  sticky: a sampled value was not the successor of the previous sample
cur_val  output  4  registered copy of the last sampled value (val_q)

Behaviour:
- Reset (asynchronous, active-high; all registers): val_q=0, have_q=0, scan_cnt=0, dig_sel=ONES, seg=7'h7F, an=2'b11, code_err=0, seq_err=0.
- Sampling: every edge, val_q<=value and have_q<=1. cur_val=val_q.
- Successor table: 0->3, 3->5, 5->7, 7->11, 11->13, 13->1, 1->2, 2->3. Any other code has no successor.
- Sequence check at an edge: if have_q=1 and value != succ(val_q), set seq_err at that edge. If val_q is illegal, every following sample is a mismatch. The first sample after reset (have_q=0) is never sequence-checked.
- Code check: value not in the legal set sets code_err at the edge that samples it. Both flags can set on the same edge.
- Both flags are sticky and clear only on reset.
- Scan: scan_cnt increments every edge and wraps. On the edge where scan_cnt is all ones, dig_sel toggles ONES<->TENS. Two states only; no other transitions.
- Display (registered, updated every edge from the current dig_sel and val_q):
  - ONES: an=2'b10, seg=pattern(val_q mod 10).
  - TENS: if val_q>=10, an=2'b01 and seg=pattern(1). Otherwise the digit is blanked: an=2'b11, seg=7'h7F.
- Latency: value->cur_val 1 edge; value->seg/an at most 2 edges when the relevant digit is selected.
- Digit patterns (active low, g..a): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
- Reset mid-operation: immediate blank display, flags cleared. The first post-reset sample is unchecked.
- Values 0..15 are all displayed; illegal codes display normally and only raise code_err.

Decomposition:
- Shared package:
  - dig_sel state encoding (ONES=0, TENS=1)
  - blank constant 7'h7F
  - seven-segment pattern constants 0..9
  - legal-code function
  - successor function
- One natural combinational sub-module: seg7_decoder (4-bit digit -> 7-bit active-low pattern), instantiated once on the muxed digit.

Test Plan:
1. Reset, then drive 0,3,5,7,11,13,1,2,3 on consecutive edges -> code_err=0, seq_err=0 throughout; cur_val tracks value one edge late.
2. SCAN_BITS=2, hold value=13 -> an alternates 2'b10 (seg=7'h30) and 2'b01 (seg=7'h79), each for 4 clocks.
3. Hold value=7 with SCAN_BITS=2 -> ONES phase an=2'b10, seg=7'h78; TENS phase an=2'b11, seg=7'h7F.
4. After 3,5 drive 9 -> code_err and seq_err both 1 after that edge; both stay 1 after returning to a legal sequence.
5. After 5 drive 11 (legal code, wrong successor) -> seq_err=1, code_err=0.
6. Assert reset asynchronously mid-scan with flags set -> outputs go to reset values before the next edge. First post-reset sample of 7 sets no seq_err; a following 11 stays clean.
